// File: rtl/cmd_stream_pkg.sv
// cmd_stream_pkg
//   Shared definitions for the command stream decoder: the frame FSM state
//   encoding, the default frame sync marker, the fixed wire byte counts of the
//   address and data fields, and a saturating 8-bit increment helper.
package cmd_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Field sizes on the wire, independent of the command bus widths.
  localparam int ADDR_BYTES = 2;
  localparam int DATA_BYTES = 4;
  localparam int BYTE_IDX_W = $clog2(DATA_BYTES);

  // Error counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_word_assembler.sv
// cmd_word_assembler
//   Collects DATA_BYTES wire bytes (MSB first) into one command word.
//   Ports:
//     clk_i        clock
//     rst_n_i      asynchronous active-low reset
//     clear_i      hold the byte index at zero (decoder outside the data phase)
//     shift_i      accept byte_i into the word
//     byte_i       incoming data byte
//     word_done_o  this shift completes a word (combinational, same cycle)
//     word_o       assembled word, valid while word_done_o is high
module cmd_word_assembler
  import cmd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic [7:0]            byte_i,
  output logic                  word_done_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  // Only the first DATA_BYTES-1 bytes need storage; the last byte is taken
  // straight from byte_i so the word is ready in the cycle it arrives.
  logic [DATA_WIDTH-9:0]  shreg_q;
  logic [BYTE_IDX_W-1:0]  byte_idx_q;

  assign word_done_o = shift_i && (byte_idx_q == BYTE_IDX_W'(DATA_BYTES - 1));
  assign word_o      = {shreg_q, byte_i};

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the shift register is plain flops, not a memory, so resetting
      // it is cheap and keeps the datapath free of X after reset.
      shreg_q    <= '0;
      byte_idx_q <= '0;
    end else if (clear_i) begin
      // Stale bytes of a discarded partial word are shifted out by the next
      // full word, so only the index needs clearing.
      byte_idx_q <= '0;
    end else if (shift_i) begin
      shreg_q    <= {shreg_q[DATA_WIDTH-17:0], byte_i};
      byte_idx_q <= word_done_o ? '0 : byte_idx_q + BYTE_IDX_W'(1);
    end
  end

endmodule

// File: rtl/cmd_stream_decoder.sv
// cmd_stream_decoder
//   Turns a host byte stream into single-word command bus writes.
//   Frame: SYNC, COUNT (1..255), ADDR_HI, ADDR_LO, COUNT x 4 data bytes
//   (MSB first). Each word is written one cycle after its last byte, with the
//   address incrementing (modulo 2**ADDR_WIDTH) per word. Stray bytes,
//   zero-count frames and timed-out frames are counted in err_count_o.
//   Optional build macro CMD_STREAM_DECODER_TIMEOUT_EN adds an idle timeout
//   that aborts a stalled frame after TIMEOUT_CYCLES cycles without a byte.
//   Ports:
//     clk_i, rst_n_i        clock, asynchronous active-low reset
//     byte_i/byte_valid_i   input byte stream
//     byte_ready_o          high in every cycle after reset (never stalls)
//     wr_addr_o/wr_data_o   command bus address/data, held between writes
//     wr_valid_o            one-cycle write strobe per word
//     busy_o                frame in progress
//     err_count_o           saturating count of dropped bytes/frames
module cmd_stream_decoder
  import cmd_stream_pkg::*;
#(
  parameter int         ADDR_WIDTH = 16,
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
`ifdef CMD_STREAM_DECODER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_valid_o,
  output logic                  busy_o,
  output logic [7:0]            err_count_o
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            words_left_q;
  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  wr_valid_q;
  logic [7:0]            err_q;

  logic                  accept;
  logic                  timeout_hit;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word;

  assign accept = byte_valid_i && ready_q;

  cmd_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_asm (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clear_i     (state_q != ST_DATA),
    .shift_i     (accept && (state_q == ST_DATA)),
    .byte_i      (byte_i),
    .word_done_o (word_done),
    .word_o      (word)
  );

`ifdef CMD_STREAM_DECODER_TIMEOUT_EN
  logic [31:0] idle_cnt_q;

  // Abort fires on the cycle the counter already sits at TIMEOUT_CYCLES-1
  // and still no byte arrives.
  assign timeout_hit = (state_q != ST_IDLE) && !accept &&
                       (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) || accept || timeout_hit) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      ready_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_valid_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      ready_q    <= 1'b1;
      wr_valid_q <= 1'b0;

      if (timeout_hit) begin
        state_q <= ST_IDLE;
        err_q   <= sat_inc8(err_q);
      end else if (accept) begin
        unique case (state_q)
          ST_IDLE: begin
            if (byte_i == SYNC_BYTE) state_q <= ST_COUNT;
            else                     err_q   <= sat_inc8(err_q);
          end
          ST_COUNT: begin
            if (byte_i == 8'd0) begin
              state_q <= ST_IDLE;
              err_q   <= sat_inc8(err_q);
            end else begin
              words_left_q <= byte_i;
              state_q      <= ST_ADDR_HI;
            end
          end
          ST_ADDR_HI: begin
            addr_q  <= ADDR_WIDTH'(byte_i);
            state_q <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr_q  <= ADDR_WIDTH'({addr_q[7:0], byte_i});
            state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (word_done) begin
              wr_valid_q   <= 1'b1;
              wr_addr_q    <= addr_q;
              wr_data_q    <= word;
              addr_q       <= addr_q + ADDR_WIDTH'(1);
              words_left_q <= words_left_q - 8'd1;
              if (words_left_q == 8'd1) state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign byte_ready_o = ready_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign wr_valid_o   = wr_valid_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign err_count_o  = err_q;

endmodule
